// File: rtl/tran2.sv
// tran2: framed byte-stream transmit stage with an optional trailing XOR checksum.
// Build option: define TRAN2_CHECKSUM_EN to accumulate and append the per-frame checksum byte.
module tran2 #(
   parameter int          DW       = 8,
   parameter logic [DW-1:0] CHK_INIT = 8'h00
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          start,
   input  logic          byt,
   input  logic [DW-1:0] DB,
   output logic [DW-1:0] Out,
   output logic          Out_en
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [DW-1:0]   out_r;
   logic [DW-1:0]   out_s;
   logic            out_en_r;
   logic            out_en_s;
   logic [7:0]      cnt_r;
   logic [7:0]      cnt_s;

`ifdef TRAN2_CHECKSUM_EN
   logic [DW-1:0]   chk_r;
   logic [DW-1:0]   chk_s;

   function automatic logic [DW-1:0] chk_fold(input logic [DW-1:0] acc,
                                              input logic [DW-1:0] data);
      return acc ^ data;
   endfunction
`endif

   // Next-state and next-output decode; outputs are only ever taken from registers.
   always_comb begin
      state_s  = state_r;
      out_s    = out_r;
      out_en_s = 1'b0;
      cnt_s    = cnt_r;
`ifdef TRAN2_CHECKSUM_EN
      chk_s    = chk_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_FRAME;
`ifdef TRAN2_CHECKSUM_EN
               chk_s   = CHK_INIT;
`endif
               // First byte may arrive on the same edge that opens the frame.
               if (byt) begin
                  out_s    = DB;
                  out_en_s = 1'b1;
                  cnt_s    = cnt_r + 8'd1;
`ifdef TRAN2_CHECKSUM_EN
                  chk_s    = chk_fold(CHK_INIT, DB);
`endif
               end else begin
                  out_en_s = 1'b0;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FRAME: begin
            if (start) begin
               if (byt) begin
                  out_s    = DB;
                  out_en_s = 1'b1;
                  cnt_s    = cnt_r + 8'd1;
`ifdef TRAN2_CHECKSUM_EN
                  chk_s    = chk_fold(chk_r, DB);
`endif
               end else begin
                  out_en_s = 1'b0;
               end
            end else begin
               // Frame end: byt is ignored here, the trailer (if any) takes this slot.
               state_s = ST_IDLE;
               cnt_s   = 8'd0;
`ifdef TRAN2_CHECKSUM_EN
               out_s    = chk_r;
               out_en_s = 1'b1;
`else
               out_en_s = 1'b0;
`endif
            end
         end
         default: begin
            state_s  = ST_IDLE;
            out_en_s = 1'b0;
            cnt_s    = 8'd0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_r  <= ST_IDLE;
         out_r    <= {DW{1'b0}};
         out_en_r <= 1'b0;
         cnt_r    <= 8'd0;
      end else begin
         state_r  <= state_s;
         out_r    <= out_s;
         out_en_r <= out_en_s;
         cnt_r    <= cnt_s;
      end
   end

`ifdef TRAN2_CHECKSUM_EN
   // Running checksum; reset discards any partial frame.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         chk_r <= CHK_INIT;
      end else begin
         chk_r <= chk_s;
      end
   end
`endif

   assign Out    = out_r;
   assign Out_en = out_en_r;

endmodule

// File: tb/tb_tran2.sv
// Scoreboard bench for tran2: stimulus queues expected bytes with their cycle, a forked monitor checks them.
module tb_tran2;

   logic       Clk;
   logic       Rst;
   logic       start;
   logic       byt;
   logic [7:0] DB;
   logic [7:0] Out;
   logic       Out_en;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc;
   int   n_vec;
   int   n_err;

   tran2 #(.DW(8), .CHK_INIT(8'h00)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .start  (start),
      .byt    (byt),
      .DB     (DB),
      .Out    (Out),
      .Out_en (Out_en)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input logic s, input logic b, input logic [7:0] d);
      start = s;
      byt   = b;
      DB    = d;
      @(posedge Clk);
      #1;
   endtask

   // expected byte appears after the next edge
   task automatic expect_byte(input logic [7:0] d);
      exp_t e;
      e.data = d;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] d);
      expect_byte(d);
      step(1'b1, 1'b1, d);
   endtask

   task automatic end_frame(input logic [7:0] chk_byte);
`ifdef TRAN2_CHECKSUM_EN
      expect_byte(chk_byte);
`else
      if (chk_byte == 8'h00) begin end else begin end
`endif
      step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic chk_out(input string nm, input logic en, input logic [7:0] o);
      chk({nm, "_en"}, {7'd0, Out_en}, {7'd0, en});
      chk({nm, "_out"}, Out, o);
   endtask

   initial begin
      exp_t e;
      n_vec = 0;
      n_err = 0;
      Rst   = 1'b0;
      start = 1'b0;
      byt   = 1'b0;
      DB    = 8'h00;

      fork
         forever begin
            @(negedge Clk);
            if (Out_en === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_pulse", Out, 8'hxx);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_byte", Out, e.data);
                  n_vec++;
                  if (cyc != e.cyc) begin
                     n_err++;
                     $display("FAIL sb_cycle: byte %h at cycle %0d, expected cycle %0d", Out, cyc, e.cyc);
                  end
               end
            end
         end
      join_none

      // reset held with active inputs
      Rst = 1'b0;
      step(1'b1, 1'b1, 8'hFF);
      chk_out("reset1", 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'hFF);
      chk_out("reset2", 1'b0, 8'h00);
      Rst = 1'b1;

      // framing gate
      step(1'b0, 1'b0, 8'hAA);
      chk_out("gate_idle", 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'hAA);
      chk_out("gate_open", 1'b0, 8'h00);

      // data path
      send(8'hF0);
      chk_out("data_f0", 1'b1, 8'hF0);
      step(1'b1, 1'b0, 8'h33);
      chk_out("data_hold", 1'b0, 8'hF0);
      send(8'hF3);
      chk_out("data_f3", 1'b1, 8'hF3);
      end_frame(8'h03);
`ifdef TRAN2_CHECKSUM_EN
      chk_out("chk_byte", 1'b1, 8'h03);
      step(1'b0, 1'b0, 8'h00);
      chk_out("chk_after", 1'b0, 8'h03);
`else
      chk_out("no_chk", 1'b0, 8'hF3);
      step(1'b0, 1'b0, 8'h00);
      chk_out("no_chk_after", 1'b0, 8'hF3);
`endif

      // byt outside a frame is ignored
      step(1'b0, 1'b1, 8'h77);
      chk("idle_byt_en", {7'd0, Out_en}, 8'd0);

      // back-to-back frames with one low cycle; byt high on the low cycle is ignored
      send(8'h12);
`ifdef TRAN2_CHECKSUM_EN
      expect_byte(8'h12);
`endif
      step(1'b0, 1'b1, 8'h99);
      send(8'h34);
      end_frame(8'h34);
      step(1'b0, 1'b0, 8'h00);

      // long continuous frame: counter wraps, XOR of 0..255 is 0, then ^0^1^2 = 3
      for (int i = 0; i < 259; i++) begin
         send(i[7:0]);
      end
      end_frame(8'h03);
      step(1'b0, 1'b0, 8'h00);

      // mid-frame reset discards the frame
      send(8'h55);
      Rst = 1'b0;
      step(1'b1, 1'b0, 8'hEE);
      chk_out("midrst", 1'b0, 8'h00);
      Rst = 1'b1;
      step(1'b1, 1'b0, 8'h00);
      send(8'h0F);
      end_frame(8'h0F);
      repeat (3) step(1'b0, 1'b0, 8'h00);

      chk("sb_drained", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tran2.md
# tran2

Byte-stream transmit stage. While `start` frames a packet, each byte on `DB` strobed by `byt` is registered onto `Out` with a one-cycle `Out_en` pulse. When `start` falls, an optional XOR checksum byte is appended. It sits between a byte-producing source and a downstream serializer/link that consumes `Out`/`Out_en`.

## Interface
- `DW`, 8, data byte width; the design and verification cover only 8.
- `CHK_INIT`, 8'h00, initial value of the running checksum at each frame start.

Ports:
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  frame enable; high for the whole duration of a frame.
- `byt`  in  1  byte strobe; `DB` is valid when `start` and `byt` are both high.
- `DB`  in  DW  input data byte.
- `Out`  out  DW  registered output byte.
- `Out_en`  out  1  output valid; a one-cycle pulse per emitted byte.

## Operation
- FSM states: IDLE and FRAME. Reset forces IDLE.
- IDLE:
  - If `start`=1 at the edge, go to FRAME and load the checksum with `CHK_INIT`.
  - If `byt`=1 at that same edge, also accept `DB` (see FRAME).
- FRAME, edge with `start`=1 and `byt`=1:
  - `Out` <= `DB`, `Out_en` <= 1.
  - Checksum <= checksum XOR `DB`.
  - 8-bit byte counter increments; it wraps at 255→0 with no error.
- FRAME, edge with `start`=1 and `byt`=0:
  - `Out_en` <= 0; `Out` holds its last value.
- FRAME, edge with `start`=0: end of frame.
  - With checksum enabled: `Out` <= checksum, `Out_en` <= 1.
  - Without checksum: `Out_en` <= 0.
  - In both cases go to IDLE and clear the counter.
  - `byt` is ignored at this edge.
- `byt` while `start`=0 in IDLE is ignored: no output, `Out` holds.
- `Out` is never cleared except by reset; consumers qualify it with `Out_en`.
- Back-to-back frames:
  - `start` 1→0→1 with a single low cycle is two frames.
  - The checksum emits on the low cycle.
  - The new frame's first byte can be accepted on the very next edge.
- Reset mid-frame: the frame is discarded and no checksum is emitted.

## Timing
- Reset values, at the first edge with `Rst`=0: `Out`=0, `Out_en`=0, state IDLE, checksum=`CHK_INIT`, counter=0.
- Latency: 1 cycle from the sampling edge to `Out`/`Out_en`. Both are registered; there is no combinational input→output path.
- Throughput: one byte per cycle. `byt` may stay high continuously; each cycle then yields one `Out_en` pulse.
- The checksum byte appears exactly one cycle after the last edge at which `start`=1, i.e. on the edge where `start` is first sampled low.
- No backpressure; the downstream must accept every `Out_en` pulse.

## Configuration
- Macro `TRAN2_CHECKSUM_EN`.
- Defined:
  - XOR checksum is accumulated per frame.
  - The checksum is emitted as a trailing byte with `Out_en`=1 on frame end.
- Undefined:
  - No checksum register or accumulation logic.
  - Frame end just returns to IDLE with `Out_en`=0.
  - Output stream = accepted data bytes only.

## Test plan
- Reset: hold `Rst`=0 for 2 cycles with `start`=1, `byt`=1, `DB`=8'hFF → `Out`=8'h00, `Out_en`=0 throughout.
- Framing gate: after reset, `DB`=8'hAA, `start`=0, `byt`=0, then `start`=1, `byt`=0 → `Out_en` stays 0, `Out`=8'h00.
- Data path, with `start`=1:
  - `byt`=1, `DB`=8'hF0 → next cycle `Out`=8'hF0, `Out_en`=1.
  - `byt`=0, `DB`=8'h33 → `Out_en`=0, `Out` holds 8'hF0.
  - `byt`=1, `DB`=8'hF3 → `Out`=8'hF3, `Out_en`=1.
- Checksum (macro defined, `CHK_INIT`=0):
  - Frame bytes 8'hF0 and 8'hF3, then `start`=0.
  - Expected: one cycle `Out`=8'h03 with `Out_en`=1, then `Out_en`=0.
  - Macro undefined: no trailing byte.
- Back-to-back frames: `start` low for exactly one cycle between frames of {8'h12} and {8'h34}.
  - With checksum: stream 12, 12, 34, 34 on consecutive `Out_en` pulses.
  - Without checksum: stream 12, 34.
- Mid-frame reset: after 8'h55 is accepted, pulse `Rst`=0 for one cycle while `start` stays 1.
  - Expected: `Out`=0, `Out_en`=0.
  - The next frame's checksum excludes 8'h55.
